// File: rtl/fp_resp_checker_if.sv
// rtl/fp_resp_checker_if.sv - expected-entry and fp_unit response channels for fp_resp_checker
interface fp_resp_checker_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_result;
    logic [4:0]  exp_flags;
    logic        exp_nan_relax;
    logic        exp_last;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;

    modport master (
        output exp_valid, exp_result, exp_flags, exp_nan_relax, exp_last,
        output rsp_valid, rsp_result, rsp_flags,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_result, exp_flags, exp_nan_relax, exp_last,
        input  rsp_valid, rsp_result, rsp_flags,
        output exp_ready
    );
endinterface

// File: rtl/fp_resp_checker.sv
// rtl/fp_resp_checker.sv - buffers expected fp_unit results and sticks on the first mismatch
module fp_resp_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    fp_resp_checker_if.slave     bus,
    output logic [CNT_W-1:0]     checked_count,
    output logic                 fail,
    output logic                 err_underflow,
    output logic                 done,
    output logic [CNT_W-1:0]     fail_index,
    output logic [31:0]          fail_result_ref,
    output logic [31:0]          fail_result_calc,
    output logic [4:0]           fail_flags_ref,
    output logic [4:0]           fail_flags_calc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 39;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_FAIL, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic [CNT_W-1:0]   r_checked;
    logic               r_fail;
    logic               r_underflow;
    logic               r_done;
    logic [CNT_W-1:0]   r_fail_index;
    logic [31:0]        r_ref_result;
    logic [31:0]        r_calc_result;
    logic [4:0]         r_ref_flags;
    logic [4:0]         r_calc_flags;

    logic               w_restart;
    logic               w_exp_ready;
    logic               w_push;
    logic               w_rsp;
    logic               w_underflow;
    logic               w_match;
    logic               w_mismatch;
    logic [ENT_W-1:0]   w_head;
    logic [31:0]        w_head_result;
    logic [4:0]         w_head_flags;
    logic               w_head_relax;
    logic               w_head_last;
    logic               w_relax_cmp;
    logic               w_result_diff;
    logic               w_flags_diff;

    assign w_restart     = reset || clear;
    assign w_exp_ready   = (r_state == ST_RUN) && (r_count < FULL_CNT);
    assign w_push        = bus.exp_valid && w_exp_ready;
    assign w_rsp         = bus.rsp_valid && (r_state == ST_RUN);
    assign w_underflow   = w_rsp && (r_count == '0);

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_result = w_head[38:7];
    assign w_head_flags  = w_head[6:2];
    assign w_head_relax  = w_head[1];
    assign w_head_last   = w_head[0];

    // A canonical NaN from the unit only has to agree on exponent and quiet bit.
    assign w_relax_cmp   = w_head_relax && (bus.rsp_result == 32'h7FC0_0000);
    assign w_result_diff = w_relax_cmp ? |(w_head_result[30:22] ^ bus.rsp_result[30:22])
                                       : |(w_head_result ^ bus.rsp_result);
    assign w_flags_diff  = |(w_head_flags ^ bus.rsp_flags);

    assign w_match       = w_rsp && (r_count != '0) && !w_result_diff && !w_flags_diff;
    assign w_mismatch    = w_rsp && (r_count != '0) && (w_result_diff || w_flags_diff);

    assign bus.exp_ready    = w_exp_ready;
    assign checked_count    = r_checked;
    assign fail             = r_fail;
    assign err_underflow    = r_underflow;
    assign done             = r_done;
    assign fail_index       = r_fail_index;
    assign fail_result_ref  = r_ref_result;
    assign fail_result_calc = r_calc_result;
    assign fail_flags_ref   = r_ref_flags;
    assign fail_flags_calc  = r_calc_flags;

    // Next state: leave RUN on the first bad compare or on a matched last entry.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_underflow || w_mismatch) begin
                    w_state_next = ST_FAIL;
                end else if (w_match && w_head_last) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (w_restart) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Entry storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.exp_result, bus.exp_flags, bus.exp_nan_relax, bus.exp_last};
        end
    end

    // FIFO pointers and occupancy; only matched entries are consumed.
    always_ff @(posedge clock) begin
        if (w_restart) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_match) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_match})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Match counter, sticky status and failure capture.
    always_ff @(posedge clock) begin
        if (w_restart) begin
            r_checked     <= '0;
            r_fail        <= 1'b0;
            r_underflow   <= 1'b0;
            r_done        <= 1'b0;
            r_fail_index  <= '0;
            r_ref_result  <= '0;
            r_calc_result <= '0;
            r_ref_flags   <= '0;
            r_calc_flags  <= '0;
        end else if (w_match) begin
            if (r_checked != {CNT_W{1'b1}}) begin
                r_checked <= r_checked + 1'b1;
            end
            if (w_head_last) begin
                r_done <= 1'b1;
            end
        end else if (w_mismatch || w_underflow) begin
            r_fail        <= 1'b1;
            r_underflow   <= w_underflow;
            r_fail_index  <= r_checked;
            r_ref_result  <= w_underflow ? 32'h0 : w_head_result;
            r_ref_flags   <= w_underflow ? 5'h0 : w_head_flags;
            r_calc_result <= bus.rsp_result;
            r_calc_flags  <= bus.rsp_flags;
        end
    end
endmodule
